// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - register-file write-port arbiter with long-latency result queue and pending scoreboard
// Optional starvation guard enabled by defining REGWR_STARVE_GUARD_EN.
module reg_write_arbiter #(
   parameter int QDEPTH       = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_valid,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        wb_stall,
   input  logic        lu_issue,
   input  logic [4:0]  lu_issue_reg,
   input  logic        lu_valid,
   input  logic [4:0]  lu_reg,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   input  logic [4:0]  rd_reg0,
   input  logic [4:0]  rd_reg1,
   input  logic [4:0]  iss_dst,
   output logic        hazard,
   output logic        ctl_regWrite,
   output logic [4:0]  instrToWrite,
   output logic [31:0] reg_writeData,
   output logic [2:0]  queue_count
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   if (QDEPTH < 1 || QDEPTH > 4) begin : gBadDepth
      $error("QDEPTH must be in 1..4");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gBadLimit
      $error("STARVE_LIMIT must be in 1..255");
   end

   logic [4:0]    qReg  [QDEPTH];
   logic [31:0]   qData [QDEPTH];
   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [2:0]    count;
   logic [31:0]   pending;

   logic        push;
   logic        pop;
   logic        wbWin;
   logic        winValid;
   logic [4:0]  winReg;
   logic [31:0] winData;
   logic [31:0] setMask;
   logic [31:0] clrMask;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Acceptance looks only at the registered count, so a full queue refuses
   // a push even when it is popping in the same cycle.
   assign lu_ready    = (count < 3'(QDEPTH));
   assign push        = lu_valid && lu_ready;
   assign queue_count = count;

   assign wbWin = wb_valid && !wb_stall;
   assign pop   = !wbWin && (count != 3'd0);

   always_comb begin
      winValid = 1'b0;
      winReg   = '0;
      winData  = '0;
      if (wbWin) begin
         winValid = 1'b1;
         winReg   = wb_reg;
         winData  = wb_data;
      end else if (pop) begin
         winValid = 1'b1;
         winReg   = qReg[headPtr];
         winData  = qData[headPtr];
      end
   end

`ifdef REGWR_STARVE_GUARD_EN
   logic [7:0] ageCnt;

   // When the head has lost STARVE_LIMIT times, hold the pipeline for one cycle.
   assign wb_stall = (ageCnt == 8'(STARVE_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ageCnt <= '0;
      end else if (pop) begin
         ageCnt <= '0;
      end else if (count != 3'd0) begin
         ageCnt <= ageCnt + 8'd1;
      end
   end
`else
   assign wb_stall = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (push) begin
         qReg[tailPtr]  <= lu_reg;
         qData[tailPtr] <= lu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (push) begin
            tailPtr <= nextPtr(tailPtr);
         end
         if (pop) begin
            headPtr <= nextPtr(headPtr);
         end
         count <= count + {2'b00, push} - {2'b00, pop};
      end
   end

   // Set beats clear on a same-register collision; register 0 is never tracked.
   assign setMask = lu_issue ? (32'b1 << lu_issue_reg) : 32'b0;
   assign clrMask = pop ? (32'b1 << qReg[headPtr]) : 32'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= ((pending & ~clrMask) | setMask) & ~32'b1;
      end
   end

   assign hazard = ((rd_reg0 != 5'd0) && pending[rd_reg0]) ||
                   ((rd_reg1 != 5'd0) && pending[rd_reg1]) ||
                   ((iss_dst != 5'd0) && pending[iss_dst]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_regWrite  <= 1'b0;
         instrToWrite  <= '0;
         reg_writeData <= '0;
      end else if (winValid && (winReg != 5'd0)) begin
         ctl_regWrite  <= 1'b1;
         instrToWrite  <= winReg;
         reg_writeData <= winData;
      end else begin
         ctl_regWrite  <= 1'b0;
         instrToWrite  <= '0;
         reg_writeData <= '0;
      end
   end

endmodule
